uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter on the system clock: accepts bytes through a valid/ready handshake into an internal FIFO and serialises them 8N1, LSB first, on `o_Tx_Data`. It has an integrated baud divider, so it needs no external tick. It is the standalone transmit end for designs that instantiate only the receive path of the UART controller, and it drives the RX controller's serial input directly.

## Interface
- `CLOCK_RATE`, default 25000000: `clk` frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. Bit period `DIV = CLOCK_RATE / BAUD_RATE`, integer-truncated (217 at defaults). `DIV` ≥ 2 is required.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of 2 and ≥ 2.
- `clk`  in  1  system clock; every flop is rising-edge.
- `reset`  in  1  reset, synchronous and active-high.
- `i_Tx_Valid`  in  1  a byte is offered on `i_Tx_Byte`.
- `i_Tx_Byte`  in  8  byte to transmit.
- `o_Tx_Ready`  out  1  FIFO not full. Equals `count != FIFO_DEPTH` (combinational from the count register).
- `o_Tx_Data`  out  1  serial line, registered; idles high.
- `o_Tx_Active`  out  1  high while in START, DATA or STOP.
- `o_Tx_Done`  out  1  one-cycle pulse at the end of each frame.
- `o_Fifo_Count`  out  $clog2(FIFO_DEPTH+1)  number of FIFO entries, excluding the byte being shifted.

## Operation
- Reset values: `o_Tx_Data`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, `o_Fifo_Count`=0, `o_Tx_Ready`=1. Reset also clears state to IDLE, the FIFO pointers, the baud counter and the bit index.
- Write: a byte is accepted on an edge where `i_Tx_Valid & o_Tx_Ready`. A write while full is ignored and nothing is stored.
- FIFO: circular buffer. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Write and pop on the same edge: count is unchanged.
  - A pop only occurs when count > 0.
- State machine, with baud counter `bc` (0..DIV-1) and bit index `bi` (0..7):
  - IDLE: line=1. If count > 0: pop the head into the shift register, `bc`←0, go to START.
  - START: line=0 for DIV cycles. When `bc`=DIV-1: `bc`←0, `bi`←0, go to DATA.
  - DATA: line=shift[`bi`] for DIV cycles per bit. When `bc`=DIV-1: if `bi`=7 go to STOP, else `bi`++.
  - STOP: line=1 for DIV cycles. When `bc`=DIV-1: go to IDLE and assert `o_Tx_Done` for that one IDLE cycle.
- Back-to-back frames: the IDLE cycle that follows STOP pops the next byte if one is present. Inter-frame gap is exactly 1 clk of idle-high beyond the stop bit.
- Reset mid-frame aborts the frame:
  - line is high on the next cycle;
  - no `o_Tx_Done` pulse;
  - all FIFO contents are discarded.

## Timing
- Latency: a byte written on edge E into an empty, idle block is popped on E+1. `o_Tx_Data` falls on E+2 and `o_Tx_Active` rises on E+2.
- Frame length: 10·DIV cycles of START/DATA/STOP, plus 1 IDLE cycle.
  - `o_Tx_Active` low for exactly 1 cycle between consecutive frames.
  - `o_Tx_Done` high in that same cycle.
- `o_Fifo_Count` reflects writes and pops one edge after they occur. `o_Tx_Ready` follows in the same cycle.
- The shift register holds one byte in addition to the FIFO, so FIFO_DEPTH+1 bytes can be outstanding.

## Test plan
- Single byte: CLOCK_RATE=1600, BAUD_RATE=100 (DIV=16); write 0xA5 at edge E.
  - Line is low E+2..E+17, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then high for 16 cycles.
  - `o_Tx_Done` pulses once at E+162; `o_Tx_Active` high E+2..E+161.
- Back-to-back: write 0x01, 0x80, 0xFF on consecutive edges.
  - Three frames with the correct bit patterns.
  - Exactly 1 idle cycle between frames.
  - Three `o_Tx_Done` pulses.
  - `o_Fifo_Count` sequence 1,1,2, then decrements at each pop.
- Fill (DIV=16, FIFO_DEPTH=8): hold `i_Tx_Valid`=1 with an incrementing byte 0x00.. every cycle.
  - Exactly 9 bytes (0x00..0x08) accepted; `o_Tx_Ready` low from E+9.
  - Ready reasserts one cycle after the next pop; then 0x09 is accepted.
  - Output order is 0x00, 0x01, ….
- Write while full: keep `i_Tx_Valid`=1 with 0xEE while `o_Tx_Ready`=0 → 0xEE is never transmitted and the count never exceeds 8.
- Reset mid-frame: assert `reset` for 1 cycle during DATA bit 3 with 4 bytes queued.
  - Next cycle: `o_Tx_Data`=1, `o_Tx_Active`=0, count 0, ready 1; no `o_Tx_Done`.
  - Line stays high until a new write.
- Loopback: connect `o_Tx_Data` to the UART RX controller (RX_OVERSAMPLE=16, matching rates) and send 0x00, 0x55, 0xFF → RX `o_Rx_Byte` matches each byte, with one `o_Rx_Done` per frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Buffered 8N1 UART transmitter with an integrated baud divider. Bytes enter
// an internal circular FIFO through a valid/ready handshake and are shifted
// out LSB first on a registered, idle-high serial line.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   i_Tx_Valid    byte offered on i_Tx_Byte
//   i_Tx_Byte     byte to transmit
//   o_Tx_Ready    FIFO not full
//   o_Tx_Data     serial line (registered, idles high)
//   o_Tx_Active   high while START, DATA or STOP is on the line
//   o_Tx_Done     one-cycle pulse in the idle cycle that ends each frame
//   o_Fifo_Count  queued bytes, excluding the byte being shifted
module uart_tx_fifo #(
  parameter int CLOCK_RATE = 25000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_Tx_Valid,
  input  logic [7:0]                        i_Tx_Byte,
  output logic                              o_Tx_Ready,
  output logic                              o_Tx_Data,
  output logic                              o_Tx_Active,
  output logic                              o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Fifo_Count
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] bc, bc_n;
  logic [2:0]    bi, bi_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en, pop, line_n, done_n, done_pend;

  assign o_Tx_Ready   = (count != CW'(FIFO_DEPTH));
  assign wr_en        = i_Tx_Valid & o_Tx_Ready;
  assign o_Fifo_Count = count;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    bc_n    = bc;
    bi_n    = bi;
    shift_n = shift;
    pop     = 1'b0;
    done_n  = 1'b0;
    line_n  = 1'b1;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          bc_n    = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        line_n = 1'b0;
        if (bc == BC_LAST) begin
          bc_n    = '0;
          bi_n    = '0;
          state_n = S_DATA;
        end else begin
          bc_n = bc + BW'(1);
        end
      end
      S_DATA: begin
        line_n = shift[bi];
        if (bc == BC_LAST) begin
          bc_n = '0;
          if (bi == 3'd7) state_n = S_STOP;
          else            bi_n    = bi + 3'd1;
        end else begin
          bc_n = bc + BW'(1);
        end
      end
      S_STOP: begin
        if (bc == BC_LAST) begin
          bc_n    = '0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          bc_n = bc + BW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= i_Tx_Byte;
  end

  // Line/active outputs are registered from the current state, so they trail
  // the state by one edge; done is piped an extra stage so it lands in the
  // same cycle that o_Tx_Active drops after the stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      bc          <= '0;
      bi          <= '0;
      shift       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_Tx_Data   <= 1'b1;
      o_Tx_Active <= 1'b0;
      done_pend   <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      bc          <= bc_n;
      bi          <= bi_n;
      shift       <= shift_n;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      o_Tx_Data   <= line_n;
      o_Tx_Active <= (state != S_IDLE);
      done_pend   <= done_n;
      o_Tx_Done   <= done_pend;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CLOCK_RATE = 1600;
  localparam int BAUD_RATE  = 100;
  localparam int DEPTH      = 8;
  localparam int DIV        = CLOCK_RATE / BAUD_RATE;
  localparam int FRAME      = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_Tx_Valid = 1'b0;
  logic [7:0] i_Tx_Byte = '0;
  logic       o_Tx_Ready, o_Tx_Data, o_Tx_Active, o_Tx_Done;
  logic [3:0] o_Fifo_Count;

  uart_tx_fifo #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_Tx_Valid   (i_Tx_Valid),
    .i_Tx_Byte    (i_Tx_Byte),
    .o_Tx_Ready   (o_Tx_Ready),
    .o_Tx_Data    (o_Tx_Data),
    .o_Tx_Active  (o_Tx_Active),
    .o_Tx_Done    (o_Tx_Done),
    .o_Fifo_Count (o_Fifo_Count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued-byte count plus a frame timer. A pop can only
  // happen when the transmitter is free; after a pop it is busy for one full
  // frame (10 bit periods) and pops again on the following edge.
  logic [7:0] exp_q[$];
  int         mcount = 0;
  int         timer  = 0;
  logic       last_acc = 1'b0;
  int         frames_done = 0;
  int         done_cnt = 0;
  logic       model_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] b, input logic r);
    logic popn;
    if (r) begin
      mcount = 0;
      timer  = 0;
      exp_q.delete();
      last_acc = 1'b0;
    end else begin
      last_acc = v && (mcount != DEPTH);
      popn     = (timer == 0) && (mcount > 0);
      if (timer != 0) timer--;
      else if (popn) timer = FRAME;
      if (last_acc) exp_q.push_back(b);
      mcount = mcount + (last_acc ? 1 : 0) - (popn ? 1 : 0);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic r);
    i_Tx_Valid = v;
    i_Tx_Byte  = b;
    reset      = r;
    @(posedge clk);
    model_edge(v, b, r);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || mcount != 0) && k < 5000) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check("drain_timeout", exp_q.size(), 0);
    for (int j = 0; j < 4; j++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Count/ready follow the model every cycle.
  always @(negedge clk) begin
    if (model_en && !reset) begin
      check("fifo_count", o_Fifo_Count, mcount);
      check("tx_ready", o_Tx_Ready, (mcount != DEPTH));
    end
    if (o_Tx_Done) done_cnt++;
  end

  // Serial monitor: finds a start bit, samples mid-bit, compares the decoded
  // byte with the head of the scoreboard, then checks the trailing idle cycle.
  initial begin
    logic [9:0] bits;
    logic       abort, act_ok;
    forever begin
      @(negedge clk);
      if (!reset && model_en && o_Tx_Data == 1'b0) begin
        abort  = 1'b0;
        act_ok = 1'b1;
        bits   = '1;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          if (!o_Tx_Active) act_ok = 1'b0;
          if (i % DIV == DIV / 2) bits[i / DIV] = o_Tx_Data;
        end
        if (!abort) begin
          check("start_bit", bits[0], 1'b0);
          check("stop_bit", bits[9], 1'b1);
          check("active_in_frame", act_ok, 1'b1);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {24'h0, bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            check("frame_byte", bits[8:1], exp_q.pop_front());
          end
          frames_done++;
          @(negedge clk);
          if (!reset) begin
            check("done_pulse", o_Tx_Done, 1'b1);
            check("gap_active", o_Tx_Active, 1'b0);
            check("gap_line", o_Tx_Data, 1'b1);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] nb;
    logic       line_ok, done_ok;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    model_edge(1'b0, 8'h00, 1'b1);
    check("rst_line", o_Tx_Data, 1'b1);
    check("rst_active", o_Tx_Active, 1'b0);
    check("rst_done", o_Tx_Done, 1'b0);
    check("rst_count", o_Fifo_Count, 0);
    check("rst_ready", o_Tx_Ready, 1'b1);
    model_en = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // Single byte, then exact latency checks
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("lat_e1_line", o_Tx_Data, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("lat_e2_line", o_Tx_Data, 1'b0);
    check("lat_e2_active", o_Tx_Active, 1'b1);
    drain();

    // Back-to-back
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    drain();

    // Fill, with 0xEE offered whenever the model says the FIFO is full
    nb = 8'h00;
    for (int c = 0; c < 1700; c++) begin
      if (mcount != DEPTH) begin
        step(1'b1, nb, 1'b0);
        if (last_acc) nb = nb + 8'd1;
      end else begin
        step(1'b1, 8'hEE, 1'b0);
      end
    end
    drain();

    // Randomised traffic: sparse phase, then a heavy phase that saturates
    for (int c = 0; c < 3000; c++) begin
      int pct;
      pct = (c < 1200) ? 1 : 25;
      step(($urandom % 100) < pct, 8'($urandom), 1'b0);
    end
    drain();

    // Reset during DATA bit 3 with bytes queued
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 66; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("mid_rst_line", o_Tx_Data, 1'b1);
    check("mid_rst_active", o_Tx_Active, 1'b0);
    check("mid_rst_count", o_Fifo_Count, 0);
    check("mid_rst_ready", o_Tx_Ready, 1'b1);
    line_ok = 1'b1;
    done_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (o_Tx_Data !== 1'b1) line_ok = 1'b0;
      if (o_Tx_Done !== 1'b0) done_ok = 1'b0;
    end
    check("post_rst_line_high", line_ok, 1'b1);
    check("post_rst_no_done", done_ok, 1'b0 == 1'b0 ? done_ok : 1'b0);
    check("post_rst_done_low", done_ok, 1'b1);
    step(1'b1, 8'h3C, 1'b0);
    drain();

    check("done_total", done_cnt, frames_done);
    check("frames_min", (frames_done >= 20), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
